filter_grant_collector: RTL and testbench
=========================================

Name: filter_grant_collector

Overview:
- Requester side of the filter round-robin arbitration interface.
- Buffers results from NUM_FILTERS filters in per-filter FIFOs and presents one request bit per non-empty FIFO to the round-robin arbiter.
- Pops the granted FIFO and serialises the winning entries onto one shared output stream with back-pressure.
- Sits between the filter bank and the downstream force/accumulation path.

Parameters:
- NUM_FILTERS, MD_pkg::NUM_FILTERS: number of filters and requesters.
- DATA_WIDTH, 64: payload width per filter entry.
- FIFO_DEPTH, 8: entries per filter FIFO; must be a power of 2 and at least 2.

Ports:
- clk  in  1  single clock for the whole block.
- rst_n  in  1  asynchronous, active-low reset.
- i_filter_valid  in  NUM_FILTERS  per-filter push strobe.
- i_filter_data  in  NUM_FILTERS x DATA_WIDTH  per-filter payload.
- o_filter_ready  out  NUM_FILTERS  FIFO not full.
- o_request  out  NUM_FILTERS  to arbiter i_request; bit k = FIFO k non-empty.
- o_arbiter_en  out  1  to arbiter i_arbiter_en; output slot can accept this cycle.
- i_grant  in  NUM_FILTERS  from arbiter o_grant; one-hot or zero.
- o_out_valid  out  1  output register holds valid data.
- o_out_data  out  DATA_WIDTH  granted payload.
- o_out_src_idx  out  FILTER_IDX_WIDTH  index of the source filter.
- i_out_ready  in  1  downstream accepts this cycle.
- o_grant_err  out  1  sticky error flag.

Behaviour:
- Reset (rst_n low, asynchronous): all FIFO counts and pointers = 0. o_out_valid = 0, o_out_data = 0, o_out_src_idx = 0, o_grant_err = 0. The reset is applied immediately, also mid-transfer; in-flight entries are discarded.
- Push: on a clk edge with i_filter_valid[k] && o_filter_ready[k], data is written into FIFO k.
- o_filter_ready[k] = (count[k] != FIFO_DEPTH). It is registered-count based and has no combinational path from i_grant.
- Push while full is ignored; the data is dropped and the count is unchanged.
- o_request[k] = (count[k] != 0), decoded from registered state.
- o_arbiter_en = !o_out_valid || i_out_ready. This is a combinational path from i_out_ready.
- Valid pop: requires o_arbiter_en, i_grant one-hot, and grant bit k with count[k] != 0. At the next edge:
  - FIFO k read pointer advances.
  - o_out_data is loaded with the FIFO k head.
  - o_out_src_idx = k.
  - o_out_valid = 1.
- No valid pop, with i_out_ready high: o_out_valid clears to 0.
- No valid pop, with i_out_ready low: the output register holds.
- Simultaneous push and pop on the same FIFO: count unchanged, both pointers advance. A FIFO at count = FIFO_DEPTH is still not ready that cycle.
- Latency:
  - Push at edge t makes the request visible after t.
  - The grant pops at edge t+1.
  - o_out_valid is high after t+1.
  - Minimum push-to-output is 2 cycles.
- Throughput: one entry per cycle when i_out_ready is held high.
- Pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. Counts are log2(FIFO_DEPTH)+1 bits.
- Grant errors: the following cause no pop and set o_grant_err (sticky until reset):
  - i_grant with more than one bit set;
  - a grant to an empty FIFO;
  - any grant while o_arbiter_en = 0.
- Zero grant while requests are pending: no pop, no error.
- o_out_data and o_out_src_idx are stable while o_out_valid && !i_out_ready.

Decomposition:
- MD_pkg, existing: NUM_FILTERS, FILTER_IDX_WIDTH.
- MD_pkg, new: OUT_FIFO_DEPTH, and typedef filter_out_t (logic [DATA_WIDTH-1:0]).
- Sub-module filter_out_fifo: single-clock FIFO with push, pop, full, empty and count outputs, instantiated NUM_FILTERS times.
- Top level keeps the grant check, the one-hot-to-index encoder, the output mux and the output register.

Test Plan:
- Reset and single entry: reset, then push 0xA5 on filter 2 with the arbiter loop-back (priority starting at filter 0).
  - Response: o_request = 0b0100 next cycle; o_out_valid = 1, o_out_data = 0xA5, o_out_src_idx = 2 two cycles after push.
- Round-robin fairness: NUM_FILTERS = 4, each filter pushes 3 entries tagged filter*16+seq, i_out_ready = 1.
  - Response: outputs in rotating source order, 12 beats on consecutive cycles, each filter's entries in seq order.
- Back-pressure: output valid, i_out_ready held low for 5 cycles.
  - Response: o_arbiter_en = 0, data and index stable, no FIFO count changes, o_grant_err = 0.
- Full FIFO: push FIFO_DEPTH+1 = 9 entries to filter 1 with i_out_ready low.
  - Response: o_filter_ready[1] = 0 after 8 pushes; 9th entry dropped; after release exactly 8 entries emerge in order.
- Bad grant: drive i_grant = 0b0011 directly, bypassing the arbiter.
  - Response: no pop, counts unchanged, o_grant_err = 1 and held until rst_n pulses low.
- Async reset mid-stream: assert rst_n low between clock edges while 3 entries are queued.
  - Response: o_out_valid = 0 and o_request = 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/filter_grant_collector_pkg.sv
// Shared constants and types for the filter grant collector: filter count,
// source index width and the per-filter result word.
package filter_grant_collector_pkg;

  localparam int NUM_FILTERS       = 4;
  localparam int FILTER_IDX_WIDTH  = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
  localparam int FILTER_DATA_WIDTH = 64;
  localparam int OUT_FIFO_DEPTH    = 8;

  typedef logic [FILTER_DATA_WIDTH-1:0] filter_out_t;

endpackage

// File: rtl/filter_grant_collector_if.sv
// Bundles the filter push side, the arbiter request/grant loop and the
// shared output stream of the grant collector.
interface filter_grant_collector_if #(
  parameter int NUM_FILTERS = filter_grant_collector_pkg::NUM_FILTERS,
  parameter int DATA_WIDTH  = filter_grant_collector_pkg::FILTER_DATA_WIDTH,
  parameter int IDX_WIDTH   = filter_grant_collector_pkg::FILTER_IDX_WIDTH
);

  logic [NUM_FILTERS-1:0]                 i_filter_valid;
  logic [NUM_FILTERS-1:0][DATA_WIDTH-1:0] i_filter_data;
  logic [NUM_FILTERS-1:0]                 o_filter_ready;
  logic [NUM_FILTERS-1:0]                 o_request;
  logic                                   o_arbiter_en;
  logic [NUM_FILTERS-1:0]                 i_grant;
  logic                                   o_out_valid;
  logic [DATA_WIDTH-1:0]                  o_out_data;
  logic [IDX_WIDTH-1:0]                   o_out_src_idx;
  logic                                   i_out_ready;
  logic                                   o_grant_err;

  modport slave (
    input  i_filter_valid, i_filter_data, i_grant, i_out_ready,
    output o_filter_ready, o_request, o_arbiter_en,
    output o_out_valid, o_out_data, o_out_src_idx, o_grant_err
  );

  modport master (
    output i_filter_valid, i_filter_data, i_grant, i_out_ready,
    input  o_filter_ready, o_request, o_arbiter_en,
    input  o_out_valid, o_out_data, o_out_src_idx, o_grant_err
  );

endinterface

// File: rtl/filter_grant_collector_out_fifo.sv
// Single-clock per-filter result FIFO; push is ignored while full and pop
// is ignored while empty, so the caller may drive both unguarded.
module filter_out_fifo #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push_i,
  input  logic [DATA_WIDTH-1:0]   data_i,
  input  logic                    pop_i,
  output logic [DATA_WIDTH-1:0]   head_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]        count_q, count_d;
  logic                  push_ok, pop_ok;

  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem[rd_ptr_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    // Simultaneous push and pop leaves the occupancy unchanged.
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/filter_grant_collector.sv
// Requester side of the filter round-robin arbiter: per-filter FIFOs raise
// requests, the granted FIFO is popped into a single back-pressured output slot.
module filter_grant_collector #(
  parameter int NUM_FILTERS = filter_grant_collector_pkg::NUM_FILTERS,
  parameter int DATA_WIDTH  = filter_grant_collector_pkg::FILTER_DATA_WIDTH,
  parameter int FIFO_DEPTH  = filter_grant_collector_pkg::OUT_FIFO_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  filter_grant_collector_if.slave bus
);

  import filter_grant_collector_pkg::FILTER_IDX_WIDTH;

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [NUM_FILTERS-1:0]                 fifo_full;
  logic [NUM_FILTERS-1:0]                 fifo_empty;
  logic [NUM_FILTERS-1:0]                 fifo_nz;
  logic [NUM_FILTERS-1:0][CNT_W-1:0]      fifo_cnt;
  logic [NUM_FILTERS-1:0][DATA_WIDTH-1:0] fifo_head;
  logic [NUM_FILTERS-1:0]                 pop_sel;

  logic                        arb_en;
  logic                        grant_onehot;
  logic                        pop_valid;
  logic [FILTER_IDX_WIDTH-1:0] pop_idx;

  logic                        out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]       out_data_q, out_data_d;
  logic [FILTER_IDX_WIDTH-1:0] out_idx_q, out_idx_d;
  logic                        grant_err_q, grant_err_d;

  function automatic logic is_onehot(input logic [NUM_FILTERS-1:0] v);
    return ($countones(v) == 1);
  endfunction

  function automatic logic [FILTER_IDX_WIDTH-1:0] onehot_to_idx(
    input logic [NUM_FILTERS-1:0] oh
  );
    logic [FILTER_IDX_WIDTH-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_FILTERS; i++) begin
      if (oh[i]) idx = idx | FILTER_IDX_WIDTH'(i);
    end
    return idx;
  endfunction

  for (genvar k = 0; k < NUM_FILTERS; k++) begin : g_fifo
    filter_out_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (bus.i_filter_valid[k]),
      .data_i  (bus.i_filter_data[k]),
      .pop_i   (pop_sel[k]),
      .head_o  (fifo_head[k]),
      .full_o  (fifo_full[k]),
      .empty_o (fifo_empty[k]),
      .count_o (fifo_cnt[k])
    );
    assign fifo_nz[k] = (fifo_cnt[k] != '0);
  end

  // Ready and request come only from registered FIFO occupancy.
  assign bus.o_filter_ready = ~fifo_full;
  assign bus.o_request      = ~fifo_empty;
  assign arb_en             = !out_valid_q || bus.i_out_ready;
  assign bus.o_arbiter_en   = arb_en;

  assign grant_onehot = is_onehot(bus.i_grant);
  assign pop_valid    = arb_en && grant_onehot && ((bus.i_grant & fifo_nz) != '0);
  assign pop_sel      = pop_valid ? bus.i_grant : '0;
  assign pop_idx      = onehot_to_idx(bus.i_grant);

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    // Any nonzero grant that does not produce a pop is an arbiter protocol error.
    grant_err_d = grant_err_q || ((bus.i_grant != '0) && !pop_valid);
    if (pop_valid) begin
      out_valid_d = 1'b1;
      out_data_d  = fifo_head[pop_idx];
      out_idx_d   = pop_idx;
    end else if (bus.i_out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      grant_err_q <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      grant_err_q <= grant_err_d;
    end
  end

  assign bus.o_out_valid   = out_valid_q;
  assign bus.o_out_data    = out_data_q;
  assign bus.o_out_src_idx = out_idx_q;
  assign bus.o_grant_err   = grant_err_q;

endmodule

// File: tb/tb_filter_grant_collector.sv
// Bench for filter_grant_collector: directed pushes with a round-robin
// arbiter loop-back, output beats checked against an expected-beat queue.
module tb_filter_grant_collector;
  import filter_grant_collector_pkg::*;

  localparam int NF = NUM_FILTERS;

  typedef struct packed {
    filter_out_t                 data;
    logic [FILTER_IDX_WIDTH-1:0] src;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  filter_grant_collector_if bus ();

  filter_grant_collector dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  beat_t exp_q[$];
  beat_t mon_e;
  int    total = 0;
  int    bad   = 0;
  int    beats = 0;

  // Arbiter loop-back: round-robin over o_request, or a manually forced grant.
  logic          arb_on;
  logic [NF-1:0] man_grant;
  logic [NF-1:0] rr_grant;
  int            rr_ptr;
  int            rr_win;

  always_comb begin
    rr_grant = '0;
    rr_win   = 0;
    if (bus.o_arbiter_en) begin
      for (int i = 0; i < NF; i++) begin
        if (rr_grant == '0 && bus.o_request[(rr_ptr + i) % NF]) begin
          rr_grant[(rr_ptr + i) % NF] = 1'b1;
          rr_win = (rr_ptr + i) % NF;
        end
      end
    end
  end

  assign bus.i_grant = arb_on ? rr_grant : man_grant;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr <= 0;
    else if (arb_on && rr_grant != '0) rr_ptr <= (rr_win + 1) % NF;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted output beat must match the head of the queue.
  always @(negedge clk) begin
    if (rst_n && bus.o_out_valid && bus.i_out_ready) begin
      beats++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_beat: got data 0x%0h src %0d, required no beat",
                 bus.o_out_data, bus.o_out_src_idx);
      end else begin
        mon_e = exp_q.pop_front();
        chk("beat_data", bus.o_out_data, mon_e.data);
        chk("beat_src", 64'(bus.o_out_src_idx), 64'(mon_e.src));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_beat(input logic [63:0] d, input int src);
    beat_t b;
    b.data = d;
    b.src  = FILTER_IDX_WIDTH'(src);
    exp_q.push_back(b);
  endtask

  task automatic drive(input int k, input logic [63:0] d);
    bus.i_filter_valid[k] = 1'b1;
    bus.i_filter_data[k]  = d;
  endtask

  task automatic release_all();
    bus.i_filter_valid = '0;
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int n;
    bus.i_filter_valid = '0;
    bus.i_filter_data  = '0;
    bus.i_out_ready    = 1'b1;
    arb_on             = 1'b1;
    man_grant          = '0;

    // Reset state
    #13;
    chk("rst_out_valid", bus.o_out_valid, 0);
    chk("rst_out_data", bus.o_out_data, 0);
    chk("rst_src_idx", 64'(bus.o_out_src_idx), 0);
    chk("rst_grant_err", bus.o_grant_err, 0);
    chk("rst_request", 64'(bus.o_request), 0);
    chk("rst_filter_ready", 64'(bus.o_filter_ready), 64'hF);
    chk("rst_arbiter_en", bus.o_arbiter_en, 1);
    rst_n = 1'b1;
    tick();

    // Single entry on filter 2
    drive(2, 64'hA5);
    expect_beat(64'hA5, 2);
    tick();
    release_all();
    chk("single_request", 64'(bus.o_request), 64'b0100);
    chk("single_valid_early", bus.o_out_valid, 0);
    tick();
    chk("single_valid", bus.o_out_valid, 1);
    chk("single_data", bus.o_out_data, 64'hA5);
    chk("single_src", 64'(bus.o_out_src_idx), 2);
    tick();
    chk("single_valid_clear", bus.o_out_valid, 0);
    chk("single_request_clear", 64'(bus.o_request), 0);

    // Round-robin fairness, priority restarting at filter 0
    do_reset();
    n = beats;
    for (int s = 0; s < 3; s++)
      for (int k = 0; k < NF; k++)
        expect_beat(64'(k * 16 + s), k);
    for (int s = 0; s < 3; s++) begin
      for (int k = 0; k < NF; k++) drive(k, 64'(k * 16 + s));
      tick();
    end
    release_all();
    for (int i = 0; i < 11; i++) tick();
    chk("rr_beat_count", 64'(beats - n), 12);
    chk("rr_queue_drained", 64'(exp_q.size()), 0);
    chk("rr_valid_after", bus.o_out_valid, 0);

    // Back-pressure
    bus.i_out_ready = 1'b0;
    drive(0, 64'h77);
    drive(3, 64'h3C);
    expect_beat(64'h77, 0);
    expect_beat(64'h3C, 3);
    tick();
    release_all();
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_arbiter_en", bus.o_arbiter_en, 0);
      chk("bp_valid", bus.o_out_valid, 1);
      chk("bp_data", bus.o_out_data, 64'h77);
      chk("bp_src", 64'(bus.o_out_src_idx), 0);
      chk("bp_request", 64'(bus.o_request), 64'b1000);
      chk("bp_grant_err", bus.o_grant_err, 0);
      tick();
    end
    bus.i_out_ready = 1'b1;
    tick();
    chk("bp_next_data", bus.o_out_data, 64'h3C);
    chk("bp_next_src", 64'(bus.o_out_src_idx), 3);
    tick();
    chk("bp_drained", 64'(exp_q.size()), 0);

    // Full FIFO on filter 1
    bus.i_out_ready = 1'b0;
    arb_on = 1'b0;
    man_grant = '0;
    for (int i = 0; i < 9; i++) begin
      chk("full_ready_before_push", bus.o_filter_ready[1], (i < 8) ? 1 : 0);
      drive(1, 64'h100 + 64'(i));
      if (i < 8) expect_beat(64'h100 + 64'(i), 1);
      tick();
    end
    release_all();
    chk("full_ready", bus.o_filter_ready[1], 0);
    chk("full_request", 64'(bus.o_request), 64'b0010);
    chk("full_grant_err", bus.o_grant_err, 0);
    arb_on = 1'b1;
    bus.i_out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    chk("full_drain_pending", 64'(exp_q.size()), 0);
    tick();
    tick();
    chk("full_ready_after", 64'(bus.o_filter_ready), 64'hF);
    chk("full_request_after", 64'(bus.o_request), 0);

    // Bad grant: two bits set
    arb_on = 1'b0;
    man_grant = '0;
    drive(0, 64'h50);
    drive(1, 64'h51);
    tick();
    release_all();
    tick();
    chk("zero_grant_no_err", bus.o_grant_err, 0);
    man_grant = 4'b0011;
    tick();
    man_grant = '0;
    chk("multi_grant_err", bus.o_grant_err, 1);
    chk("multi_grant_no_pop", bus.o_out_valid, 0);
    chk("multi_grant_request", 64'(bus.o_request), 64'b0011);
    tick();
    tick();
    tick();
    chk("multi_grant_err_sticky", bus.o_grant_err, 1);
    do_reset();
    chk("err_cleared_by_reset", bus.o_grant_err, 0);

    // Bad grant: empty FIFO
    drive(0, 64'h60);
    tick();
    release_all();
    man_grant = 4'b0100;
    tick();
    man_grant = '0;
    chk("empty_grant_err", bus.o_grant_err, 1);
    chk("empty_grant_no_pop", bus.o_out_valid, 0);
    chk("empty_grant_request", 64'(bus.o_request), 64'b0001);
    do_reset();
    chk("err_cleared_again", bus.o_grant_err, 0);

    // Bad grant: output slot blocked
    bus.i_out_ready = 1'b0;
    arb_on = 1'b1;
    drive(0, 64'h70);
    drive(1, 64'h71);
    tick();
    release_all();
    tick();
    arb_on = 1'b0;
    man_grant = 4'b0010;
    tick();
    man_grant = '0;
    chk("blocked_grant_err", bus.o_grant_err, 1);
    chk("blocked_grant_data", bus.o_out_data, 64'h70);
    chk("blocked_grant_request", 64'(bus.o_request), 64'b0010);
    do_reset();

    // Asynchronous reset with entries queued
    arb_on = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(2, 64'h81 + 64'(i));
      tick();
    end
    release_all();
    chk("async_pre_valid", bus.o_out_valid, 1);
    chk("async_pre_request", 64'(bus.o_request), 64'b0100);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid", bus.o_out_valid, 0);
    chk("async_request", 64'(bus.o_request), 0);
    chk("async_data", bus.o_out_data, 0);
    exp_q.delete();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    bus.i_out_ready = 1'b1;
    tick();
    tick();
    chk("async_after_valid", bus.o_out_valid, 0);
    chk("final_queue_empty", 64'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
